// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer for the fetch stage.
// Combinational lookup on FetchPC, 2-bit saturating direction counters,
// training from the ID-stage branch decoder, and the IF/ID-aligned Cache bit.
module branch_target_buffer #(
    parameter int ENTRIES    = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] FetchPC,
    output logic        PredTaken,
    output logic [31:0] PredTarget,
    input  logic        Stall,
    input  logic        Flush,
    output logic        Cache,
    input  logic        UpdateValid,
    input  logic [31:0] UpdatePC,
    input  logic        UpdateTaken,
    input  logic [31:0] UpdateTarget
);

    localparam int TAG_BITS = 30 - INDEX_BITS;

    // Entry storage
    logic                valid_r  [ENTRIES];
    logic [TAG_BITS-1:0] tag_r    [ENTRIES];
    logic [31:0]         target_r [ENTRIES];
    logic [1:0]          ctr_r    [ENTRIES];

    logic [INDEX_BITS-1:0] fetch_idx_s;
    logic [TAG_BITS-1:0]   fetch_tag_s;
    logic [INDEX_BITS-1:0] upd_idx_s;
    logic [TAG_BITS-1:0]   upd_tag_s;
    logic                  fetch_hit_s;
    logic                  upd_hit_s;
    logic                  pred_taken_s;
    logic [31:0]           pred_target_s;
    logic                  cache_r;

    // Byte-offset bits of a word-aligned PC never take part in lookup.
    logic unused_pc_bits_s;
    assign unused_pc_bits_s = ^{FetchPC[1:0], UpdatePC[1:0]};

    assign fetch_idx_s = FetchPC[INDEX_BITS+1:2];
    assign fetch_tag_s = FetchPC[31:INDEX_BITS+2];
    assign upd_idx_s   = UpdatePC[INDEX_BITS+1:2];
    assign upd_tag_s   = UpdatePC[31:INDEX_BITS+2];

    // Saturating increment: taken at strong-T stays strong-T.
    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        logic [1:0] r;
        case (c)
            2'b11:   r = 2'b11;
            default: r = c + 2'b01;
        endcase
        return r;
    endfunction

    // Saturating decrement: not-taken at strong-NT stays strong-NT.
    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        logic [1:0] r;
        case (c)
            2'b00:   r = 2'b00;
            default: r = c - 2'b01;
        endcase
        return r;
    endfunction

    // Lookup: pre-update contents only, no write-to-read bypass.
    always_comb begin
        fetch_hit_s   = 1'b0;
        pred_taken_s  = 1'b0;
        pred_target_s = 32'h0000_0000;
        fetch_hit_s   = valid_r[fetch_idx_s] && (tag_r[fetch_idx_s] == fetch_tag_s);
        if (fetch_hit_s && ctr_r[fetch_idx_s][1]) begin
            pred_taken_s  = 1'b1;
            pred_target_s = target_r[fetch_idx_s];
        end else begin
            pred_taken_s  = 1'b0;
            pred_target_s = 32'h0000_0000;
        end
    end

    // Update-side hit detection for the resolved branch.
    always_comb begin
        upd_hit_s = 1'b0;
        if (valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s)) begin
            upd_hit_s = 1'b1;
        end else begin
            upd_hit_s = 1'b0;
        end
    end

    // Training: reset clears every entry; otherwise apply the resolved outcome.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= '0;
                target_r[i] <= 32'h0000_0000;
                ctr_r[i]    <= 2'b01;
            end
        end else if (UpdateValid) begin
            if (upd_hit_s) begin
                if (UpdateTaken) begin
                    ctr_r[upd_idx_s]    <= sat_inc(ctr_r[upd_idx_s]);
                    target_r[upd_idx_s] <= UpdateTarget;
                end else begin
                    ctr_r[upd_idx_s]    <= sat_dec(ctr_r[upd_idx_s]);
                end
            end else if (UpdateTaken) begin
                // Allocate or replace an aliasing entry, starting weakly taken.
                valid_r[upd_idx_s]  <= 1'b1;
                tag_r[upd_idx_s]    <= upd_tag_s;
                target_r[upd_idx_s] <= UpdateTarget;
                ctr_r[upd_idx_s]    <= 2'b10;
            end
            // A not-taken miss leaves the existing entry untouched.
        end
    end

    // IF/ID prediction register: Reset > Flush > Stall > load.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cache_r <= 1'b0;
        end else if (Flush) begin
            cache_r <= 1'b0;
        end else if (Stall) begin
            cache_r <= cache_r;
        end else begin
            cache_r <= pred_taken_s;
        end
    end

    assign PredTaken  = pred_taken_s;
    assign PredTarget = pred_target_s;
    assign Cache      = cache_r;

endmodule
